// File: rtl/interfaz_pspl_pkg.sv
// Shared constants for the PS/PL mailbox: command codes, FSM state encodings
// and the acknowledge code each state presents to the PS.
package interfaz_pspl_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int CMD_WIDTH_DEF  = 8;

    localparam int CMD_IDLE       = 0;
    localparam int CMD_RESET      = 1;
    localparam int CMD_CALC       = 2;
    localparam int CMD_SCAN       = 3;
    localparam int CMD_PRINT      = 4;
    localparam int CMD_END        = 5;
    localparam int CMD_IDLE_SYNC  = 6;
    localparam int CMD_RESET_SYNC = 7;
    localparam int CMD_CALC_SYNC  = 8;
    localparam int CMD_SCAN_SYNC  = 9;
    localparam int CMD_PRINT_SYNC = 10;

    localparam logic [3:0] ST_IDLE       = 4'd1;
    localparam logic [3:0] ST_RST        = 4'd2;
    localparam logic [3:0] ST_RST_SYNC   = 4'd3;
    localparam logic [3:0] ST_CALC       = 4'd4;
    localparam logic [3:0] ST_CALC_SYNC  = 4'd5;
    localparam logic [3:0] ST_SCAN       = 4'd6;
    localparam logic [3:0] ST_SCAN_SYNC  = 4'd7;
    localparam logic [3:0] ST_PRINT      = 4'd8;
    localparam logic [3:0] ST_PRINT_SYNC = 4'd9;

    // Acknowledge code shown on ctrl_out while the FSM sits in a given state.
    function automatic logic [7:0] ack_code(input logic [3:0] st);
        logic [7:0] code;
        code = 8'(CMD_IDLE_SYNC);
        case (st)
            ST_RST:        code = 8'(CMD_RESET);
            ST_RST_SYNC:   code = 8'(CMD_RESET_SYNC);
            ST_CALC:       code = 8'(CMD_CALC);
            ST_CALC_SYNC:  code = 8'(CMD_CALC_SYNC);
            ST_SCAN:       code = 8'(CMD_SCAN);
            ST_SCAN_SYNC:  code = 8'(CMD_SCAN_SYNC);
            ST_PRINT:      code = 8'(CMD_PRINT);
            ST_PRINT_SYNC: code = 8'(CMD_PRINT_SYNC);
            default:       code = 8'(CMD_IDLE_SYNC);
        endcase
        return code;
    endfunction

endpackage

// File: rtl/interfaz_pspl_square_core.sv
// Sequential shift-add squarer: one partial product per cycle, done pulses
// for one cycle with the low WIDTH bits of operand*operand on result.
module interfaz_pspl_square_core #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [CW-1:0]    count_reg;
    logic             busy_reg;
    logic             done_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (abort) begin
                busy_reg  <= 1'b0;
                count_reg <= '0;
            end else if (start && !busy_reg) begin
                acc_reg    <= '0;
                mcand_reg  <= operand;
                mplier_reg <= operand;
                count_reg  <= CW'(WIDTH);
                busy_reg   <= 1'b1;
            end else if (busy_reg) begin
                // Bits shifted past the top of mcand fall outside the mod-2^WIDTH result.
                if (mplier_reg[0]) begin
                    acc_reg <= acc_reg + mcand_reg;
                end
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                count_reg  <= count_reg - CW'(1);
                if (count_reg == CW'(1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign result = acc_reg;

endmodule

// File: rtl/interfaz_pspl_top.sv
// PL side of the PS/PL mailbox: registered command decode, handshake FSM,
// operand/result/data_out registers around the squaring core.
module interfaz_pspl_top
    import interfaz_pspl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CMD_WIDTH  = CMD_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [CMD_WIDTH-1:0]  ctrl_in,
    output logic [CMD_WIDTH-1:0]  ctrl_out,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [3:0]            state_dbg
);

    localparam logic [CMD_WIDTH-1:0] C_IDLE       = CMD_WIDTH'(CMD_IDLE);
    localparam logic [CMD_WIDTH-1:0] C_RESET      = CMD_WIDTH'(CMD_RESET);
    localparam logic [CMD_WIDTH-1:0] C_CALC       = CMD_WIDTH'(CMD_CALC);
    localparam logic [CMD_WIDTH-1:0] C_SCAN       = CMD_WIDTH'(CMD_SCAN);
    localparam logic [CMD_WIDTH-1:0] C_PRINT      = CMD_WIDTH'(CMD_PRINT);
    localparam logic [CMD_WIDTH-1:0] C_RESET_SYNC = CMD_WIDTH'(CMD_RESET_SYNC);
    localparam logic [CMD_WIDTH-1:0] C_SCAN_SYNC  = CMD_WIDTH'(CMD_SCAN_SYNC);
    localparam logic [CMD_WIDTH-1:0] C_PRINT_SYNC = CMD_WIDTH'(CMD_PRINT_SYNC);

    logic [CMD_WIDTH-1:0]  ctrl_reg;
    logic [DATA_WIDTH-1:0] data_reg;
    logic [3:0]            state_reg;
    logic [3:0]            state_next;
    logic [CMD_WIDTH-1:0]  ctrl_out_reg;
    logic [DATA_WIDTH-1:0] data_out_reg;
    logic [DATA_WIDTH-1:0] operand_reg;
    logic [DATA_WIDTH-1:0] result_reg;

    logic                  core_start;
    logic                  core_abort;
    logic                  core_busy;
    logic                  core_done;
    logic [DATA_WIDTH-1:0] core_result;
    logic                  capture_operand;
    logic                  latch_result;
    logic                  load_data_out;
    logic                  clear_regs;

    always_comb begin
        state_next      = state_reg;
        core_start      = 1'b0;
        core_abort      = 1'b0;
        capture_operand = 1'b0;
        latch_result    = 1'b0;
        load_data_out   = 1'b0;
        clear_regs      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ctrl_reg == C_RESET) begin
                    state_next = ST_RST;
                    clear_regs = 1'b1;
                    core_abort = 1'b1;
                end else if (ctrl_reg == C_SCAN) begin
                    state_next = ST_SCAN;
                end else if (ctrl_reg == C_CALC) begin
                    state_next = ST_CALC;
                    core_start = 1'b1;
                end else if (ctrl_reg == C_PRINT) begin
                    state_next    = ST_PRINT;
                    load_data_out = 1'b1;
                end
            end
            ST_SCAN: begin
                if (ctrl_reg == C_IDLE) begin
                    state_next = ST_IDLE;
                end else if (ctrl_reg == C_SCAN_SYNC) begin
                    state_next      = ST_SCAN_SYNC;
                    capture_operand = 1'b1;
                end
            end
            ST_CALC: begin
                // An idle while computing abandons the run; result_reg keeps its old value.
                if (ctrl_reg == C_IDLE) begin
                    state_next = ST_IDLE;
                    core_abort = 1'b1;
                end else if (core_done) begin
                    state_next   = ST_CALC_SYNC;
                    latch_result = 1'b1;
                end
            end
            ST_PRINT: begin
                if (ctrl_reg == C_IDLE) begin
                    state_next = ST_IDLE;
                end else if (ctrl_reg == C_PRINT_SYNC) begin
                    state_next = ST_PRINT_SYNC;
                end
            end
            ST_RST: begin
                if (ctrl_reg == C_IDLE) begin
                    state_next = ST_IDLE;
                end else if (ctrl_reg == C_RESET_SYNC) begin
                    state_next = ST_RST_SYNC;
                end
            end
            ST_SCAN_SYNC, ST_CALC_SYNC, ST_PRINT_SYNC, ST_RST_SYNC: begin
                if (ctrl_reg == C_IDLE) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_reg     <= '0;
            data_reg     <= '0;
            state_reg    <= ST_IDLE;
            ctrl_out_reg <= CMD_WIDTH'(CMD_IDLE_SYNC);
            data_out_reg <= '0;
            operand_reg  <= '0;
            result_reg   <= '0;
        end else begin
            ctrl_reg     <= ctrl_in;
            data_reg     <= data_in;
            state_reg    <= state_next;
            // Acknowledge tracks the state being entered so it lines up with state_dbg.
            ctrl_out_reg <= CMD_WIDTH'(ack_code(state_next));
            if (clear_regs) begin
                operand_reg <= '0;
                result_reg  <= '0;
            end
            if (capture_operand) begin
                operand_reg <= data_reg;
            end
            if (latch_result) begin
                result_reg <= core_result;
            end
            if (load_data_out) begin
                data_out_reg <= result_reg;
            end
        end
    end

    interfaz_pspl_square_core #(
        .WIDTH(DATA_WIDTH)
    ) u_core (
        .clock  (clock),
        .reset  (reset),
        .start  (core_start),
        .abort  (core_abort),
        .operand(operand_reg),
        .busy   (core_busy),
        .done   (core_done),
        .result (core_result)
    );

    assign ctrl_out  = ctrl_out_reg;
    assign data_out  = data_out_reg;
    assign state_dbg = state_reg;

endmodule

// File: tb/tb_interfaz_pspl_top.sv
// Directed + randomized bench for the PS/PL mailbox; squares are predicted
// with plain 64-bit arithmetic and the handshake from the command table.
module tb_interfaz_pspl_top;

    localparam int CI_IDLE = 0, CI_RESET = 1, CI_CALC = 2, CI_SCAN = 3, CI_PRINT = 4, CI_END = 5;
    localparam int CI_IDLE_SYNC = 6, CI_RESET_SYNC = 7, CI_CALC_SYNC = 8, CI_SCAN_SYNC = 9, CI_PRINT_SYNC = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  ctrl_in = 8'd0;
    logic [7:0]  ctrl_out;
    logic [31:0] data_in = 32'd0;
    logic [31:0] data_out;
    logic [3:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_operand = 32'd0;
    logic [31:0] model_result  = 32'd0;
    logic [31:0] model_dout    = 32'd0;

    always #5 clock = ~clock;

    interfaz_pspl_top dut (
        .clock    (clock),
        .reset    (reset),
        .ctrl_in  (ctrl_in),
        .ctrl_out (ctrl_out),
        .data_in  (data_in),
        .data_out (data_out),
        .state_dbg(state_dbg)
    );

    function automatic logic [31:0] square32(input logic [31:0] v);
        logic [63:0] w;
        w = {32'd0, v} * {32'd0, v};
        return w[31:0];
    endfunction

    // State the PS should see reported for each acknowledge code.
    function automatic logic [31:0] state_for_ack(input int ack);
        case (ack)
            CI_RESET:      return 32'd2;
            CI_RESET_SYNC: return 32'd3;
            CI_CALC:       return 32'd4;
            CI_CALC_SYNC:  return 32'd5;
            CI_SCAN:       return 32'd6;
            CI_SCAN_SYNC:  return 32'd7;
            CI_PRINT:      return 32'd8;
            CI_PRINT_SYNC: return 32'd9;
            default:       return 32'd1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input int cmd);
        @(negedge clock);
        ctrl_in = 8'(cmd);
    endtask

    task automatic wait_ack(input int ack, input string tag, output int cycles);
        cycles = 0;
        while (cycles < 80 && ctrl_out !== 8'(ack)) begin
            @(negedge clock);
            cycles++;
        end
        check({tag, "_ack"}, 32'(ctrl_out), 32'(ack));
        check({tag, "_state"}, 32'(state_dbg), state_for_ack(ack));
    endtask

    task automatic full_cycle(input logic [31:0] op, input bit noise);
        int cyc;
        send(CI_SCAN);
        wait_ack(CI_SCAN, "scan", cyc);
        if (noise) begin
            repeat (3) begin
                @(negedge clock);
                data_in = $urandom;
            end
        end
        @(negedge clock);
        data_in = op;
        ctrl_in = 8'(CI_SCAN_SYNC);
        model_operand = op;
        wait_ack(CI_SCAN_SYNC, "scan_sync", cyc);
        if (noise) data_in = $urandom;
        send(CI_IDLE);
        wait_ack(CI_IDLE_SYNC, "scan_idle", cyc);
        send(CI_CALC);
        wait_ack(CI_CALC_SYNC, "calc_sync", cyc);
        checks++;
        assert (cyc >= 33 && cyc <= 40) else begin
            errors++;
            $error("FAIL calc_latency observed=%0d expected=33..40", cyc);
        end
        model_result = square32(model_operand);
        send(CI_IDLE);
        wait_ack(CI_IDLE_SYNC, "calc_idle", cyc);
        send(CI_PRINT);
        wait_ack(CI_PRINT, "print", cyc);
        model_dout = model_result;
        check("data_out", data_out, model_dout);
        send(CI_PRINT_SYNC);
        wait_ack(CI_PRINT_SYNC, "print_sync", cyc);
        check("data_out_hold", data_out, model_dout);
        send(CI_IDLE);
        wait_ack(CI_IDLE_SYNC, "print_idle", cyc);
        $display("txn op=0x%08h data_out=0x%08h expected=0x%08h", op, data_out, model_dout);
    endtask

    task automatic print_only(input string tag);
        int cyc;
        send(CI_PRINT);
        wait_ack(CI_PRINT, "print", cyc);
        model_dout = model_result;
        check(tag, data_out, model_dout);
        send(CI_PRINT_SYNC);
        wait_ack(CI_PRINT_SYNC, "print_sync", cyc);
        send(CI_IDLE);
        wait_ack(CI_IDLE_SYNC, "print_idle", cyc);
        $display("txn print data_out=0x%08h expected=0x%08h", data_out, model_dout);
    endtask

    initial begin
        int cyc;
        logic [31:0] op;

        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_ctrl_out", 32'(ctrl_out), 32'd6);
        check("reset_data_out", data_out, 32'd0);
        check("reset_state", 32'(state_dbg), 32'd1);
        $display("txn reset ctrl_out=%0d state=%0d", ctrl_out, state_dbg);

        for (int n = 0; n < 10; n++) full_cycle(32'(n), 1'b0);
        full_cycle(32'h0000_FFFF, 1'b0);
        full_cycle(32'h0001_0000, 1'b0);
        for (int k = 0; k < 6; k++) begin
            op = $urandom;
            full_cycle(op, 1'b1);
        end

        // end=5 in IDLE holds IDLE
        send(CI_END);
        repeat (5) @(negedge clock);
        check("end_hold_ack", 32'(ctrl_out), 32'd6);
        check("end_hold_state", 32'(state_dbg), 32'd1);
        send(CI_IDLE);
        @(negedge clock);

        // Abort a calculation on a freshly scanned operand
        send(CI_SCAN);
        wait_ack(CI_SCAN, "ab_scan", cyc);
        @(negedge clock);
        data_in = 32'd12345;
        ctrl_in = 8'(CI_SCAN_SYNC);
        model_operand = 32'd12345;
        wait_ack(CI_SCAN_SYNC, "ab_scan_sync", cyc);
        send(CI_IDLE);
        wait_ack(CI_IDLE_SYNC, "ab_idle", cyc);
        send(CI_CALC);
        repeat (5) @(negedge clock);
        check("abort_in_calc", 32'(ctrl_out), 32'd2);
        ctrl_in = 8'(CI_IDLE);
        wait_ack(CI_IDLE_SYNC, "abort_idle", cyc);
        print_only("abort_keeps_result");

        // Reset command: clears operand/result but not data_out
        send(CI_RESET);
        wait_ack(CI_RESET, "rst", cyc);
        check("rst_keeps_data_out", data_out, model_dout);
        model_operand = 32'd0;
        model_result  = 32'd0;
        send(CI_RESET_SYNC);
        wait_ack(CI_RESET_SYNC, "rst_sync", cyc);
        send(CI_IDLE);
        wait_ack(CI_IDLE_SYNC, "rst_idle", cyc);
        send(CI_CALC);
        wait_ack(CI_CALC_SYNC, "rst_calc", cyc);
        model_result = square32(model_operand);
        send(CI_IDLE);
        wait_ack(CI_IDLE_SYNC, "rst_calc_idle", cyc);
        print_only("rst_then_print");

        // Async reset during a calculation
        full_cycle(32'd7, 1'b0);
        send(CI_CALC);
        repeat (10) @(negedge clock);
        check("pre_async_ctrl", 32'(ctrl_out), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("async_ctrl_out", 32'(ctrl_out), 32'd6);
        check("async_state", 32'(state_dbg), 32'd1);
        check("async_data_out", data_out, 32'd0);
        $display("txn async_reset ctrl_out=%0d state=%0d data_out=0x%08h", ctrl_out, state_dbg, data_out);
        ctrl_in = 8'(CI_IDLE);
        model_operand = 32'd0;
        model_result  = 32'd0;
        model_dout    = 32'd0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        print_only("after_async_print");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
